mem_port_arbiter: RTL and testbench

Arbitrates one single-port, fixed-latency unified memory between the instruction-fetch port and the data-access port of the 5-stage RV32I pipeline. It sequences every memory transaction through a small state machine and returns a one-cycle acknowledge with read data. It drives the stall requests that the hazard logic uses to hold IF and MEM while a port waits. Data accesses have priority, with a starvation guard that guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port, fixed-latency memory shared by the fetch and data ports.
// Data wins contention; a starvation counter forces a fetch grant after STARVE_LIM data wins.
module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_kill_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_ack_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_if_o,
  output logic        stall_mem_o
);

  // IDLE arbitrate | ISSUE memory strobe | WAIT latency down-count | RESP ack
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam logic [3:0] LP_WAIT_LOAD  = 4'(MEM_LAT - 1);
  localparam logic [3:0] LP_STARVE_LIM = 4'(STARVE_LIM);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_gnt_if;
  logic        r_kill_pend;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_cap;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        w_if_elig;
  logic        w_any_req;
  logic        w_gnt_if;
  logic        w_in_resp;
  logic        w_if_ack;
  logic        w_d_ack;

  assign w_if_elig = if_req_i & ~if_kill_i;
  assign w_any_req = d_req_i | w_if_elig;
  assign w_gnt_if  = w_if_elig & (~d_req_i | (r_starve == LP_STARVE_LIM));
  assign w_in_resp = (r_state == ST_RESP);
  // A flush landing in the response cycle still cancels the fetch ack
  assign w_if_ack  = w_in_resp & r_gnt_if & ~r_kill_pend & ~if_kill_i;
  assign w_d_ack   = w_in_resp & ~r_gnt_if;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt       <= 4'd0;
      r_starve    <= 4'd0;
      r_gnt_if    <= 1'b0;
      r_kill_pend <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_cap       <= 32'd0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
    end else begin
      if ((r_state != ST_IDLE) && r_gnt_if && if_kill_i) r_kill_pend <= 1'b1;
      if (w_if_ack) r_if_rdata <= r_cap;
      if (w_d_ack && !r_mem_we) r_d_rdata <= r_cap;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt_if    <= w_gnt_if;
            r_kill_pend <= 1'b0;
            r_mem_we    <= ~w_gnt_if & d_we_i;
            r_mem_addr  <= w_gnt_if ? if_addr_i : d_addr_i;
            r_mem_wdata <= w_gnt_if ? 32'd0 : d_wdata_i;
            if (w_gnt_if || !w_if_elig)          r_starve <= 4'd0;
            else if (r_starve != LP_STARVE_LIM)  r_starve <= r_starve + 4'd1;
          end
        end
        ST_ISSUE: r_cnt <= LP_WAIT_LOAD;
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_cap <= mem_rdata_i;
          else               r_cnt <= r_cnt - 4'd1;
        end
        ST_RESP: r_kill_pend <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req_o   = (r_state == ST_ISSUE);
    mem_we_o    = r_mem_we;
    mem_addr_o  = r_mem_addr;
    mem_wdata_o = r_mem_wdata;
    if_ack_o    = w_if_ack;
    d_ack_o     = w_d_ack;
    if_rdata_o  = w_if_ack ? r_cap : r_if_rdata;
    d_rdata_o   = (w_d_ack & ~r_mem_we) ? r_cap : r_d_rdata;
    stall_if_o  = if_req_i & ~w_if_ack & ~if_kill_i;
    stall_mem_o = d_req_i & ~w_d_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: three instances with different latency and
// starvation limits, each checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L  = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    localparam int SL = (g == 0) ? 2 : (g == 1) ? 4 : 3;

    logic        rst;
    logic        if_req, if_kill, if_ack, d_req, d_we, d_ack;
    logic        mem_req, mem_we, stall_if, stall_mem;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    bit          fin = 1'b0;
    bit          kill_prev = 1'b0;

    mem_port_arbiter #(.MEM_LAT(L), .STARVE_LIM(SL)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_kill_i(if_kill),
      .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_ack_o(d_ack), .d_rdata_o(d_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .stall_if_o(stall_if), .stall_mem_o(stall_mem)
    );

    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] content(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pick_addr();
      logic [31:0] r;
      r = $urandom;
      case (r % 4)
        0: return 32'h40;
        1: return 32'h100;
        2: return 32'h200;
        default: return r & 32'hFFFF_FFFC;
      endcase
    endfunction

    // Model: a grant decided at cycle t0 issues at t0+1 and responds at t0+2+L
    int          cyc = 0, t0 = 0, starve = 0, pend_cyc = -1;
    bit          busy = 0, gport = 0, killed = 0, g_we = 0, f_done = 0, d_done = 0;
    logic [31:0] g_data = 0, exp_if_rd = 0, exp_d_rd = 0, pend_data = 0;

    always @(posedge clk or posedge rst) begin
      bit fe;
      if (rst) begin
        busy = 0; killed = 0; starve = 0; pend_cyc = -1;
        exp_if_rd = 0; exp_d_rd = 0; f_done = 0; d_done = 0;
        cyc++;
      end else begin
        f_done = 0;
        d_done = 0;
        if (mem_req) begin
          if (mem_we) mem[mem_addr] = mem_wdata;
          else begin
            pend_cyc  = cyc + L;
            pend_data = content(mem_addr);
          end
        end
        if (busy) begin
          if (gport && if_kill) killed = 1;
          if (cyc == t0 + 2 + L) begin
            if (gport && !killed) begin exp_if_rd = g_data; f_done = 1; end
            if (!gport) begin
              if (!g_we) exp_d_rd = g_data;
              d_done = 1;
            end
            busy = 0;
          end
        end else begin
          fe = if_req && !if_kill;
          if (d_req || fe) begin
            busy   = 1;
            t0     = cyc;
            killed = 0;
            gport  = fe && (!d_req || starve == SL);
            if (gport || !fe) starve = 0;
            else if (starve < SL) starve = starve + 1;
            g_we   = gport ? 1'b0 : d_we;
            g_data = content(gport ? if_addr : d_addr);
          end
        end
        cyc++;
      end
    end

    always @(posedge clk) begin
      #1;
      mem_rdata = (cyc == pend_cyc) ? pend_data : $urandom;
    end

    always @(negedge clk) begin
      bit          rs, a_f, a_d;
      logic [31:0] e_if, e_d;
      rs   = busy && (cyc == t0 + 2 + L);
      a_f  = rs && gport && !killed && !if_kill;
      a_d  = rs && !gport;
      e_if = a_f ? g_data : exp_if_rd;
      e_d  = (a_d && !g_we) ? g_data : exp_d_rd;
      check_eq($sformatf("L%0d c%0d mem_req", L, cyc), 32'(mem_req), 32'(busy && cyc == t0 + 1));
      check_eq($sformatf("L%0d c%0d if_ack", L, cyc), 32'(if_ack), 32'(a_f));
      check_eq($sformatf("L%0d c%0d d_ack", L, cyc), 32'(d_ack), 32'(a_d));
      check_eq($sformatf("L%0d c%0d if_rdata", L, cyc), if_rdata, e_if);
      check_eq($sformatf("L%0d c%0d d_rdata", L, cyc), d_rdata, e_d);
      check_eq($sformatf("L%0d c%0d stall_if", L, cyc), 32'(stall_if), 32'(if_req && !a_f && !if_kill));
      check_eq($sformatf("L%0d c%0d stall_mem", L, cyc), 32'(stall_mem), 32'(d_req && !a_d));
      if (busy && cyc == t0 + 1) begin
        check_eq($sformatf("L%0d c%0d mem_we", L, cyc), 32'(mem_we), 32'(g_we));
        check_eq($sformatf("L%0d c%0d mem_addr", L, cyc), mem_addr, gport ? if_addr : d_addr);
        check_eq($sformatf("L%0d c%0d mem_wdata", L, cyc), mem_wdata, gport ? 32'd0 : d_wdata);
      end
    end

    task automatic drive_rand();
      bit kp;
      kp = kill_prev;
      if (!if_req || f_done || kp) begin
        if_req  = ($urandom % 3) != 0;
        if_addr = pick_addr();
      end
      if_kill   = ($urandom % 10) == 0;
      kill_prev = if_kill;
      if (!d_req || d_done) begin
        d_req   = $urandom % 2;
        d_we    = $urandom % 2;
        d_addr  = pick_addr();
        d_wdata = $urandom;
      end
    endtask

    initial begin
      int n, lat, k;
      rst = 1'b1; if_req = 0; if_kill = 0; d_req = 0; d_we = 0;
      if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
      mem[32'h100] = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      check_eq($sformatf("L%0d reset mem_addr", L), mem_addr, 32'd0);
      check_eq($sformatf("L%0d reset mem_we", L), 32'(mem_we), 32'd0);
      check_eq($sformatf("L%0d reset mem_wdata", L), mem_wdata, 32'd0);
      rst = 1'b0;

      repeat (600) begin @(posedge clk); #1; drive_rand(); end

      n = 0;
      while (!(busy && cyc >= t0 + 2 && cyc <= t0 + 1 + L) && n < 400) begin
        @(posedge clk); #1; drive_rand(); n++;
      end
      check_eq($sformatf("L%0d reach WAIT", L), 32'(n < 400), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq($sformatf("L%0d rst mem_req", L), 32'(mem_req), 32'd0);
      check_eq($sformatf("L%0d rst mem_we", L), 32'(mem_we), 32'd0);
      check_eq($sformatf("L%0d rst mem_addr", L), mem_addr, 32'd0);
      check_eq($sformatf("L%0d rst mem_wdata", L), mem_wdata, 32'd0);
      check_eq($sformatf("L%0d rst if_ack", L), 32'(if_ack), 32'd0);
      check_eq($sformatf("L%0d rst d_ack", L), 32'(d_ack), 32'd0);
      check_eq($sformatf("L%0d rst if_rdata", L), if_rdata, 32'd0);
      check_eq($sformatf("L%0d rst d_rdata", L), d_rdata, 32'd0);
      if_req = 0; d_req = 0; if_kill = 0; kill_prev = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h40;
      lat = 0;
      do begin @(posedge clk); #1; lat++; end while (!if_ack && lat < 40);
      check_eq($sformatf("L%0d fetch latency", L), 32'(lat), 32'(L + 2));
      check_eq($sformatf("L%0d fetch data", L), if_rdata, content(32'h40));
      @(posedge clk); #1;
      if_req = 1'b0;

      // Both ports saturated: grants must follow SL data wins then one fetch
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = pick_addr(); d_wdata = $urandom;
      k = 0; n = 0;
      while (k < 6 && n < 300) begin
        @(posedge clk); #1; n++;
        if (f_done) if_addr = if_addr + 32'd4;
        if (d_done) begin d_addr = pick_addr(); d_we = $urandom % 2; d_wdata = $urandom; end
        if (if_ack || d_ack) begin
          check_eq($sformatf("L%0d grant %0d is fetch", L, k), 32'(if_ack), 32'(((k + 1) % (SL + 1)) == 0));
          k++;
        end
      end
      check_eq($sformatf("L%0d saturation grants", L), 32'(k), 32'd6);

      repeat (300) begin @(posedge clk); #1; drive_rand(); end
      fin = 1'b1;
    end
  end

  initial begin
    int w;
    w = 0;
    while (!(gi[0].fin && gi[1].fin && gi[2].fin) && w < 20000) begin
      @(posedge clk); w++;
    end
    if (w >= 20000) check_eq("run timeout", 32'(w), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
